// File: rtl/spart_core_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spart_core_if                                                 |
// | Purpose  : Bus-side control and status signals between the bus driver    |
// |            and the SPART.                                                |
// |   iocs    chip select                    (driver -> spart)               |
// |   iorw    1 = read, 0 = write            (driver -> spart)               |
// |   ioaddr  register select                (driver -> spart)               |
// |   rda     receive data available         (spart  -> driver)              |
// |   tbr     transmit buffer ready          (spart  -> driver)              |
// |  The shared databus is a plain inout net on the SPART so that its        |
// |  tristate drivers resolve on a single top-level wire.                    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface spart_core_if;
   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   logic       rda;
   logic       tbr;

   modport master (output iocs, output iorw, output ioaddr, input rda, input tbr);
   modport slave  (input iocs, input iorw, input ioaddr, output rda, output tbr);
endinterface
`default_nettype wire

// File: rtl/spart_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spart_core                                                    |
// | Purpose  : Bus-programmable UART, 8N1, LSB first, 16-bit baud divisor.   |
// | Ports    : clk     clock, posedge                                        |
// |            rst     asynchronous, active-low reset                        |
// |            bus     iocs/iorw/ioaddr in, rda/tbr out (spart_core_if)     |
// |            databus shared 8-bit bus, driven only when iocs && iorw       |
// |            txd     serial out, idle high                                 |
// |            rxd     serial in, asynchronous to clk                        |
// | Registers: 00 TX/RX buffer, 01 status {5'b0,ovr,tbr,rda},                |
// |            10 divisor low, 11 divisor high                               |
// | Options  : SPART_OVERRUN_EN - adds the overrun flag on status bit 2      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module spart_core #(
   parameter int          OVERSAMPLE = 16,
   parameter logic [15:0] DB_RESET   = 16'd325
) (
   input  wire         clk,
   input  wire         rst,
   spart_core_if.slave bus,
   inout  wire  [7:0]  databus,
   output logic        txd,
   input  wire         rxd
);

   localparam int              c_TW   = $clog2(OVERSAMPLE) + 1;
   localparam logic [c_TW-1:0] c_FULL = c_TW'(OVERSAMPLE - 1);
   localparam logic [c_TW-1:0] c_HALF = c_TW'(OVERSAMPLE / 2 - 1);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_FERR} rx_state_t;

   // ---------------- bus decode ----------------
   logic w_wr, w_rd, w_wr_buf, w_rd_buf, w_rd_stat;
   assign w_wr      = bus.iocs & ~bus.iorw;
   assign w_rd      = bus.iocs &  bus.iorw;
   assign w_wr_buf  = w_wr && (bus.ioaddr == 2'b00);
   assign w_rd_buf  = w_rd && (bus.ioaddr == 2'b00);
   assign w_rd_stat = w_rd && (bus.ioaddr == 2'b01);

   // ---------------- baud generator ----------------
   logic [15:0] r_div, r_baud_cnt;
   logic        r_reload, w_en;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_div    <= DB_RESET;
         r_reload <= 1'b0;
      end else begin
         r_reload <= 1'b0;
         if (w_wr && bus.ioaddr[1]) begin
            r_reload <= 1'b1;
            if (bus.ioaddr[0]) r_div[15:8] <= databus;
            else               r_div[7:0]  <= databus;
         end
      end
   end

   // A divisor write restarts the count one cycle later so the new rate
   // applies immediately rather than after the old count runs out.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                   r_baud_cnt <= DB_RESET;
      else if (r_reload || w_en)  r_baud_cnt <= r_div;
      else                        r_baud_cnt <= r_baud_cnt - 16'd1;
   end
   assign w_en = (r_baud_cnt == 16'd0);

   // ---------------- transmitter ----------------
   tx_state_t       r_tx_state, w_tx_next;
   logic [c_TW-1:0] r_tx_tick;
   logic [2:0]      r_tx_idx;
   logic [7:0]      r_tx_byte;
   logic            w_tx_bit_end, w_tbr;

   assign w_tx_bit_end = w_en && (r_tx_tick == c_FULL);
   assign w_tbr        = (r_tx_state == TX_IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_tx_state <= TX_IDLE;
      else      r_tx_state <= w_tx_next;
   end

   always_comb begin
      w_tx_next = r_tx_state;
      txd       = 1'b1;
      case (r_tx_state)
         TX_IDLE:  if (w_wr_buf) w_tx_next = TX_START;
         TX_START: begin
            txd = 1'b0;
            if (w_tx_bit_end) w_tx_next = TX_DATA;
         end
         TX_DATA: begin
            txd = r_tx_byte[r_tx_idx];
            if (w_tx_bit_end && (r_tx_idx == 3'd7)) w_tx_next = TX_STOP;
         end
         TX_STOP:  if (w_tx_bit_end) w_tx_next = TX_IDLE;
         default:  w_tx_next = TX_IDLE;
      endcase
   end

   // Writes to 00 are only latched while idle; a busy transmitter drops them.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tx_tick <= '0;
         r_tx_idx  <= 3'd0;
         r_tx_byte <= 8'h00;
      end else if (r_tx_state == TX_IDLE) begin
         r_tx_tick <= '0;
         r_tx_idx  <= 3'd0;
         if (w_wr_buf) r_tx_byte <= databus;
      end else if (w_en) begin
         if (w_tx_bit_end) begin
            r_tx_tick <= '0;
            if (r_tx_state == TX_DATA) r_tx_idx <= r_tx_idx + 3'd1;
         end else begin
            r_tx_tick <= r_tx_tick + 1'b1;
         end
      end
   end

   // ---------------- receiver ----------------
   logic            r_rx_meta, r_rx_sync;
   rx_state_t       r_rx_state, w_rx_next;
   logic [c_TW-1:0] r_rx_tick;
   logic [2:0]      r_rx_idx;
   logic [7:0]      r_rx_shift, r_rx_buf;
   logic            r_rda, w_rx_tick_end, w_rx_done;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
      end else begin
         r_rx_meta <= rxd;
         r_rx_sync <= r_rx_meta;
      end
   end

   // The start bit is checked half a bit in; every later sample then lands
   // a whole bit after the previous one, i.e. at mid-bit.
   assign w_rx_tick_end = w_en &&
      (r_rx_tick == ((r_rx_state == RX_START) ? c_HALF : c_FULL));
   assign w_rx_done = (r_rx_state == RX_STOP) && w_rx_tick_end && r_rx_sync;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_rx_state <= RX_IDLE;
      else      r_rx_state <= w_rx_next;
   end

   always_comb begin
      w_rx_next = r_rx_state;
      case (r_rx_state)
         RX_IDLE:  if (!r_rx_sync) w_rx_next = RX_START;
         RX_START: if (w_rx_tick_end) w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
         RX_DATA:  if (w_rx_tick_end && (r_rx_idx == 3'd7)) w_rx_next = RX_STOP;
         RX_STOP:  if (w_rx_tick_end) w_rx_next = r_rx_sync ? RX_IDLE : RX_FERR;
         RX_FERR:  if (r_rx_sync) w_rx_next = RX_IDLE;   // wait for line release
         default:  w_rx_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rx_tick  <= '0;
         r_rx_idx   <= 3'd0;
         r_rx_shift <= 8'h00;
      end else if ((r_rx_state == RX_IDLE) || (r_rx_state == RX_FERR)) begin
         r_rx_tick <= '0;
         r_rx_idx  <= 3'd0;
      end else if (w_en) begin
         if (w_rx_tick_end) begin
            r_rx_tick <= '0;
            if (r_rx_state == RX_DATA) begin
               r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
               r_rx_idx   <= r_rx_idx + 3'd1;
            end
         end else begin
            r_rx_tick <= r_rx_tick + 1'b1;
         end
      end
   end

   // Completion has priority over the read-clear of rda.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rx_buf <= 8'h00;
         r_rda    <= 1'b0;
      end else begin
         if (w_rx_done) r_rx_buf <= r_rx_shift;
         if (w_rx_done)     r_rda <= 1'b1;
         else if (w_rd_buf) r_rda <= 1'b0;
      end
   end

   logic w_ovr;
`ifdef SPART_OVERRUN_EN
   logic r_ovr;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                     r_ovr <= 1'b0;
      else if (w_rx_done && r_rda)  r_ovr <= 1'b1;
      else if (w_rd_stat)           r_ovr <= 1'b0;
   end
   assign w_ovr = r_ovr;
`else
   assign w_ovr = 1'b0;
`endif

   // ---------------- bus read path ----------------
   logic [7:0] w_rdata;
   always_comb begin
      w_rdata = 8'h00;
      case (bus.ioaddr)
         2'b00:   w_rdata = r_rx_buf;
         2'b01:   w_rdata = {5'b00000, w_ovr, w_tbr, r_rda};
         2'b10:   w_rdata = r_div[7:0];
         default: w_rdata = r_div[15:8];
      endcase
   end

   assign databus = w_rd ? w_rdata : 8'bzzzz_zzzz;
   assign bus.rda = r_rda;
   assign bus.tbr = w_tbr;

endmodule
`default_nettype wire

// File: tb/tb_spart_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_spart_core                                                 |
// | Purpose  : Self-checking bench for spart_core. A frame-level model       |
// |            (expected byte queues, rx_buf/rda/overrun flags, divisor)     |
// |            predicts bus reads, rda/tbr pins and every txd bit.           |
// |            Honours SPART_OVERRUN_EN like the design.                     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_spart_core;
   logic clk = 1'b0;
   logic rst;
   always #10 clk = ~clk;

   spart_core_if bus ();
   wire  [7:0] databus;
   logic [7:0] wdata;
   wire        txd, rxd;
   logic       loop, tb_rxd;

   assign databus = (bus.iocs && !bus.iorw) ? wdata : 8'bzzzz_zzzz;
   assign rxd     = loop ? txd : tb_rxd;

   spart_core dut (.clk(clk), .rst(rst), .bus(bus), .databus(databus), .txd(txd), .rxd(rxd));

   // ---------------- model state ----------------
   int         m_div;
   logic [7:0] m_rx_buf;
   logic       m_rda, m_ovr;
   logic [7:0] txq[$];
   bit         quiet;
   int         n_tests, n_fail;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = a; wdata = d;
      @(negedge clk);
      bus.iocs = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
      @(negedge clk);
      bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = a;
      #1 d = databus;
      @(negedge clk);
      bus.iocs = 1'b0; bus.iorw = 1'b0;
   endtask

   task automatic set_div(input int d);
      bus_write(2'b10, d[7:0]);
      bus_write(2'b11, d[15:8]);
      m_div = d;
   endtask

   task automatic rx_got(input logic [7:0] b);
`ifdef SPART_OVERRUN_EN
      m_ovr = m_ovr | m_rda;
`endif
      m_rda = 1'b1;
      m_rx_buf = b;
   endtask

   task automatic wait_tbr();
      int c = 0;
      int budget = 11 * (m_div + 1) * 16 + 20;
      while (bus.tbr !== 1'b1 && c < budget) begin @(negedge clk); c++; end
      chk("tbr_return", bus.tbr, 1'b1);
   endtask

   // Byte sent through the transmitter, looped back into the receiver.
   task automatic send_loop(input logic [7:0] b);
      quiet = 1'b0;
      txq.push_back(b);
      bus_write(2'b00, b);
      wait_tbr();
      rx_got(b);
      quiet = 1'b1;
   endtask

   task automatic read_buf(input string nm, output logic [7:0] d);
      bus_read(2'b00, d);
      chk(nm, d, m_rx_buf);
      m_rda = 1'b0;
   endtask

   task automatic status_chk(input string nm);
      logic [7:0] d;
      bus_read(2'b01, d);
      chk(nm, d, {5'b00000, m_ovr, 1'b1, m_rda});
      m_ovr = 1'b0;
   endtask

   // Bit-banged frame on rxd; stop_ok=0 holds the line low past the stop bit.
   task automatic bang(input logic [7:0] b, input bit stop_ok);
      int per = (m_div + 1) * 16;
      @(negedge clk); tb_rxd = 1'b0;
      repeat (per) @(negedge clk);
      for (int i = 0; i < 8; i++) begin tb_rxd = b[i]; repeat (per) @(negedge clk); end
      tb_rxd = stop_ok;
      repeat (per) @(negedge clk);
      if (!stop_ok) begin repeat (2 * per) @(negedge clk); tb_rxd = 1'b1; end
      repeat (per) @(negedge clk);
   endtask

   // ---------------- idle-state pin compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (quiet && rst === 1'b1) begin
            chk("rda_pin", bus.rda, m_rda);
            chk("tbr_pin", bus.tbr, 1'b1);
         end
      end
   end

   // ---------------- txd frame monitor ----------------
   logic [9:0] mon_fr;
   int         mon_per;
   bit         mon_abort;
   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && txd === 1'b0) begin
            mon_per = (m_div + 1) * 16;
            if (txq.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL txd_frame: got unexpected start bit, required idle line");
               repeat (10 * mon_per) @(negedge clk);
            end else begin
               mon_fr    = {1'b1, txq.pop_front(), 1'b0};
               mon_abort = 1'b0;
               for (int c = 0; c <= 9 * mon_per + mon_per / 2 && !mon_abort; c++) begin
                  if (c % mon_per == mon_per / 2)
                     chk($sformatf("txd_bit%0d", c / mon_per), txd, mon_fr[c / mon_per]);
                  @(negedge clk);
                  if (rst !== 1'b1) mon_abort = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got no end of test, required finish within time limit");
      $fatal(1, "time limit expired");
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [7:0] d;
      int         r;
      n_tests = 0; n_fail = 0; quiet = 1'b0;
      bus.iocs = 1'b0; bus.iorw = 1'b0; bus.ioaddr = 2'b00; wdata = 8'h00;
      loop = 1'b1; tb_rxd = 1'b1;
      m_div = 325; m_rx_buf = 8'h00; m_rda = 1'b0; m_ovr = 1'b0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_txd", txd, 1'b1);
      chk("reset_tbr", bus.tbr, 1'b1);
      chk("reset_rda", bus.rda, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      bus_read(2'b01, d); chk("reset_status", d, 8'h02);
      bus_read(2'b10, d); chk("reset_div_lo", d, 8'h45);
      bus_read(2'b11, d); chk("reset_div_hi", d, 8'h01);
      quiet = 1'b1;

      // A5 at divisor 4; second write while busy must be dropped
      set_div(4);
      quiet = 1'b0;
      txq.push_back(8'hA5);
      bus_write(2'b00, 8'hA5);
      chk("tbr_after_write", bus.tbr, 1'b0);
      repeat (100) @(negedge clk);
      bus_write(2'b00, 8'hFF);
      wait_tbr();
      rx_got(8'hA5);
      quiet = 1'b1;
      read_buf("rx_a5", d);

      // loopback 3C, rda clears the cycle after the read
      send_loop(8'h3C);
      read_buf("rx_3c", d);
      chk("rx_3c_literal", d, 8'h3C);
      chk("rda_after_read", bus.rda, 1'b0);

      // short glitch is a false start, then a clean 81
      loop = 1'b0;
      @(negedge clk); tb_rxd = 1'b0;
      repeat (3) @(negedge clk);
      tb_rxd = 1'b1;
      repeat (200) @(negedge clk);
      status_chk("status_false_start");
      quiet = 1'b0;
      bang(8'h81, 1'b1);
      rx_got(8'h81);
      quiet = 1'b1;
      read_buf("rx_81", d);
      chk("rx_81_literal", d, 8'h81);

      // framing error: nothing delivered, receiver recovers
      bang(8'h55, 1'b0);
      read_buf("rx_after_ferr", d);
      chk("rx_after_ferr_literal", d, 8'h81);
      loop = 1'b1;
      send_loop(8'h5A);
      read_buf("rx_5a", d);

      // two bytes without a read in between
      send_loop(8'h11);
      send_loop(8'h22);
      bus_read(2'b01, d);
`ifdef SPART_OVERRUN_EN
      chk("status_two_bytes", d, 8'h07);
`else
      chk("status_two_bytes", d, 8'h03);
`endif
      m_ovr = 1'b0;
      bus_read(2'b01, d);
      chk("status_after_stat_read", d, 8'h03);
      read_buf("rx_22", d);
      chk("rx_22_literal", d, 8'h22);

      // randomized divisors and bytes
      for (int i = 0; i < 8; i++) begin
         r = int'($urandom_range(0, 3));
         set_div(r);
         bus_read(2'b10, d);
         chk("rand_div_lo", d, r[7:0]);
         send_loop(8'($urandom));
         if ($urandom_range(0, 1) == 1) status_chk("rand_status");
         if ($urandom_range(0, 1) == 1) read_buf("rand_rx", d);
      end

      // asynchronous reset in the middle of a frame, with rda set
      send_loop(8'h99);
      quiet = 1'b0;
      txq.push_back(8'hF0);
      bus_write(2'b00, 8'hF0);
      repeat (60) @(negedge clk);
      #3 rst = 1'b0;
      #1;
      chk("async_rst_txd", txd, 1'b1);
      chk("async_rst_tbr", bus.tbr, 1'b1);
      chk("async_rst_rda", bus.rda, 1'b0);
      txq.delete();
      m_div = 325; m_rx_buf = 8'h00; m_rda = 1'b0; m_ovr = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      bus_read(2'b01, d); chk("post_rst_status", d, 8'h02);
      bus_read(2'b10, d); chk("post_rst_div_lo", d, 8'h45);
      read_buf("post_rst_rx_buf", d);
      quiet = 1'b1;
      repeat (20) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
